player_tracker: RTL and testbench
=================================

Name: player_tracker

Overview:
- Producer side of the game-control handshake.
- Tracks the player's grid position from debounced direction pulses and enforces the step budget.
- Drives the key/exit position flags, out_of_steps and timeout_15s consumed by the game FSM.
- Runs the 15 s exit timer whenever the FSM asserts enable_count_last.
- Sits between the button debouncers and the game FSM.

Parameters:
- GRID_W, 8, grid columns; x range 0..GRID_W-1
- GRID_H, 8, grid rows; y range 0..GRID_H-1
- START_X, 0, reset x position
- START_Y, 0, reset y position
- KEY_X, 5, key cell x
- KEY_Y, 2, key cell y
- EXIT_X, 7, exit cell x
- EXIT_Y, 7, exit cell y
- MAX_STEPS, 40, step budget; must be 1..2^STEP_W-1
- STEP_W, 6, step counter width
- CLK_HZ, 50000000, clock cycles per second
- TIMEOUT_S, 15, seconds until timeout_15s

Ports:
- clk_50MHz_i  in  1  system clock
- rst_sync_ha_i  in  1  reset; synchronous, active-high
- up_i  in  1  one-cycle pulse from debouncer; y-1
- down_i  in  1  one-cycle pulse; y+1
- left_i  in  1  one-cycle pulse; x-1
- right_i  in  1  one-cycle pulse; x+1
- enable_count_last  in  1  from game FSM; high while in EXIT state
- pos_x_o  out  $clog2(GRID_W)  current x
- pos_y_o  out  $clog2(GRID_H)  current y
- steps_left_o  out  STEP_W  remaining steps
- move_ack_o  out  1  one-cycle pulse per accepted move
- in_key_pos  out  1  position equals key cell
- in_exit_pos  out  1  position equals exit cell
- out_of_steps  out  1  step budget exhausted; sticky
- timeout_15s  out  1  exit timer expired; sticky

Behaviour:
- Clock and reset: single clock clk_50MHz_i. Reset is synchronous, active-high (rst_sync_ha_i); it is sampled only on the rising edge and overrides all other activity.
- Reset values:
  - pos = (START_X, START_Y); steps_left_o = MAX_STEPS.
  - move_ack_o, out_of_steps, timeout_15s = 0.
  - in_key_pos / in_exit_pos = the start-cell compare result.
  - Movement FSM = PLAY; timer counters = 0.
- All outputs are registered. in_key_pos and in_exit_pos are computed from the next position and update on the same edge as pos.
- Movement FSM states:
  - PLAY: direction pulses evaluated each cycle.
  - FROZEN: all direction inputs ignored; pos and steps hold.
- Transitions:
  - PLAY -> FROZEN when out_of_steps becomes 1.
  - PLAY -> FROZEN when enable_count_last is sampled high (player has exited).
  - FROZEN -> PLAY only via reset.
- Move evaluation in PLAY, on edge k:
  - Exactly one direction high and the target cell is in-grid: accepted. Position updates at edge k, steps_left decrements by 1, move_ack_o = 1 for one cycle. Latency is 1 edge.
  - Two or more directions high in the same cycle: ignored; no step consumed, no ack.
  - Target outside the grid (x=0 with left, x=GRID_W-1 with right, likewise for y): blocked. Position unchanged, no ack, no step consumed (unless WALL_COST_EN).
- Step budget:
  - An accepted move with steps_left_o == 1 sets steps_left_o = 0 and out_of_steps = 1 on the same edge.
  - If that move lands on the key or exit cell, the cell flag and out_of_steps assert together; the FSM resolves priority.
  - steps_left_o never wraps below 0.
- Exit timer (sub-module):
  - Prescaler counts 0..CLK_HZ-1 while enable_count_last is high and emits a 1-cycle tick at wrap.
  - Seconds counter increments on each tick.
  - When seconds reaches TIMEOUT_S, timeout_15s = 1 (sticky) and both counters hold.
  - enable_count_last low: counters pause and keep their values; they do not clear.
  - timeout_15s asserts exactly TIMEOUT_S*CLK_HZ enabled cycles after the first enabled cycle.
- Reset mid-game or mid-count: all state returns to reset values on the next edge; any pending pulse that cycle is discarded.

Optional Feature:
- Macro: ZORK_WALL_COST_EN.
- Defined: a single-direction move blocked by the grid edge consumes one step (steps_left decrements, may set out_of_steps). Position is unchanged and move_ack_o stays 0.
- Undefined: blocked moves are free, as specified above.

Decomposition:
- Shared package zork_pkg holds:
  - direction encoding typedef (DIR_UP/DOWN/LEFT/RIGHT/NONE);
  - movement FSM state typedef (PLAY/FROZEN);
  - default grid, key, exit, start and budget constants shared with the game FSM and display logic.
- One sub-module: exit_timer (prescaler + seconds counter + sticky timeout). It is instantiated once and parameterised by CLK_HZ and TIMEOUT_S.

Test Plan:
- Start and key: reset, then 5 right pulses and 2 down pulses.
  - pos = (5,2), in_key_pos = 1, steps_left_o = 33.
  - move_ack_o pulses 7 times.
- Blocked and simultaneous moves: at (0,0), left pulse, then up+right in the same cycle.
  - pos stays (0,0), steps_left_o = 40, no ack.
  - With ZORK_WALL_COST_EN: steps_left_o = 39 after the left pulse only.
- Budget: MAX_STEPS=3; right, left, right.
  - After the 3rd move: steps_left_o = 0, out_of_steps = 1.
  - A 4th pulse is ignored; pos stays (1,0).
- Last step onto exit: MAX_STEPS=14, pos at (7,6) with 1 step left, down pulse.
  - in_exit_pos and out_of_steps both rise on the same edge.
- Timer: CLK_HZ=10, TIMEOUT_S=3; enable_count_last high 12 cycles, low 5 cycles, high again.
  - timeout_15s rises after exactly 30 enabled cycles and stays high after enable drops.
  - Moves are ignored once enable has been seen.
- Reset mid-count: assert rst_sync_ha_i at enabled cycle 20.
  - Next edge: timer cleared, pos = start, steps_left_o = 40.
  - A full 30 enabled cycles are then needed before timeout_15s asserts.

Source files
------------

// File: rtl/zork_pkg.sv
// Shared types and default constants for the maze game: direction encoding,
// movement FSM states, and grid/key/exit/start/budget defaults.
package zork_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    typedef enum logic {
        PLAY,
        FROZEN
    } move_state_e;

    localparam int unsigned DEF_GRID_W    = 8;
    localparam int unsigned DEF_GRID_H    = 8;
    localparam int unsigned DEF_START_X   = 0;
    localparam int unsigned DEF_START_Y   = 0;
    localparam int unsigned DEF_KEY_X     = 5;
    localparam int unsigned DEF_KEY_Y     = 2;
    localparam int unsigned DEF_EXIT_X    = 7;
    localparam int unsigned DEF_EXIT_Y    = 7;
    localparam int unsigned DEF_MAX_STEPS = 40;
    localparam int unsigned DEF_STEP_W    = 6;

    // Anything other than exactly one pulse decodes to DIR_NONE.
    function automatic dir_e decode_dir(input logic [3:0] udlr);
        case (udlr)
            4'b1000: decode_dir = DIR_UP;
            4'b0100: decode_dir = DIR_DOWN;
            4'b0010: decode_dir = DIR_LEFT;
            4'b0001: decode_dir = DIR_RIGHT;
            default: decode_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/exit_timer.sv
// Exit timer: prescaler over CLK_HZ cycles feeding a seconds counter; sticky
// timeout once TIMEOUT_S seconds of enabled time have elapsed.
module exit_timer #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TIMEOUT_S = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = $clog2(TIMEOUT_S + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_LAST   = SW'(TIMEOUT_S);

    logic [PW-1:0] presc;
    logic [SW-1:0] seconds;
    logic          tick;

    assign tick = enable && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            seconds <= '0;
            timeout <= 1'b0;
        end else if (enable && !timeout) begin
            if (tick) begin
                presc   <= '0;
                seconds <= seconds + 1'b1;
                if (seconds + 1'b1 == SEC_LAST) timeout <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_tracker.sv
// Player position tracker and step budget with exit timer.
// Optional ZORK_WALL_COST_EN: moves blocked by the grid edge still cost a step.
module player_tracker
    import zork_pkg::*;
#(
    parameter int unsigned GRID_W    = DEF_GRID_W,
    parameter int unsigned GRID_H    = DEF_GRID_H,
    parameter int unsigned START_X   = DEF_START_X,
    parameter int unsigned START_Y   = DEF_START_Y,
    parameter int unsigned KEY_X     = DEF_KEY_X,
    parameter int unsigned KEY_Y     = DEF_KEY_Y,
    parameter int unsigned EXIT_X    = DEF_EXIT_X,
    parameter int unsigned EXIT_Y    = DEF_EXIT_Y,
    parameter int unsigned MAX_STEPS = DEF_MAX_STEPS,
    parameter int unsigned STEP_W    = DEF_STEP_W,
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TIMEOUT_S = 15
) (
    input  logic                      clk_50MHz_i,
    input  logic                      rst_sync_ha_i,
    input  logic                      up_i,
    input  logic                      down_i,
    input  logic                      left_i,
    input  logic                      right_i,
    input  logic                      enable_count_last,
    output logic [$clog2(GRID_W)-1:0] pos_x_o,
    output logic [$clog2(GRID_H)-1:0] pos_y_o,
    output logic [STEP_W-1:0]         steps_left_o,
    output logic                      move_ack_o,
    output logic                      in_key_pos,
    output logic                      in_exit_pos,
    output logic                      out_of_steps,
    output logic                      timeout_15s
);

    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_KEY   = XW'(KEY_X);
    localparam logic [YW-1:0] Y_KEY   = YW'(KEY_Y);
    localparam logic [XW-1:0] X_EXIT  = XW'(EXIT_X);
    localparam logic [YW-1:0] Y_EXIT  = YW'(EXIT_Y);
    localparam logic [STEP_W-1:0] STEPS_INIT = STEP_W'(MAX_STEPS);

    move_state_e   state;
    dir_e          dir;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          accept;
    logic          blocked;
    logic          use_step;

    always_comb begin
        dir     = decode_dir({up_i, down_i, left_i, right_i});
        next_x  = pos_x_o;
        next_y  = pos_y_o;
        accept  = 1'b0;
        blocked = 1'b0;
        unique case (dir)
            DIR_UP:    if (pos_y_o != '0)   begin next_y = pos_y_o - 1'b1; accept = 1'b1; end
                       else blocked = 1'b1;
            DIR_DOWN:  if (pos_y_o != Y_MAX) begin next_y = pos_y_o + 1'b1; accept = 1'b1; end
                       else blocked = 1'b1;
            DIR_LEFT:  if (pos_x_o != '0)   begin next_x = pos_x_o - 1'b1; accept = 1'b1; end
                       else blocked = 1'b1;
            DIR_RIGHT: if (pos_x_o != X_MAX) begin next_x = pos_x_o + 1'b1; accept = 1'b1; end
                       else blocked = 1'b1;
            default: ;
        endcase
`ifdef ZORK_WALL_COST_EN
        use_step = accept || blocked;
`else
        use_step = accept;
`endif
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i) begin
            state        <= PLAY;
            pos_x_o      <= X_START;
            pos_y_o      <= Y_START;
            steps_left_o <= STEPS_INIT;
            move_ack_o   <= 1'b0;
            in_key_pos   <= (X_START == X_KEY) && (Y_START == Y_KEY);
            in_exit_pos  <= (X_START == X_EXIT) && (Y_START == Y_EXIT);
            out_of_steps <= 1'b0;
        end else begin
            move_ack_o <= 1'b0;
            unique case (state)
                PLAY: begin
                    // Once the FSM reports the exit phase, the player is done moving.
                    if (enable_count_last) begin
                        state <= FROZEN;
                    end else begin
                        if (accept) begin
                            pos_x_o     <= next_x;
                            pos_y_o     <= next_y;
                            move_ack_o  <= 1'b1;
                            in_key_pos  <= (next_x == X_KEY) && (next_y == Y_KEY);
                            in_exit_pos <= (next_x == X_EXIT) && (next_y == Y_EXIT);
                        end
                        if (use_step && steps_left_o != '0) begin
                            steps_left_o <= steps_left_o - 1'b1;
                            if (steps_left_o == STEP_W'(1)) begin
                                out_of_steps <= 1'b1;
                                state        <= FROZEN;
                            end
                        end
                    end
                end
                FROZEN: ;
                default: state <= FROZEN;
            endcase
        end
    end

    exit_timer #(
        .CLK_HZ   (CLK_HZ),
        .TIMEOUT_S(TIMEOUT_S)
    ) u_exit_timer (
        .clk    (clk_50MHz_i),
        .rst    (rst_sync_ha_i),
        .enable (enable_count_last),
        .timeout(timeout_15s)
    );

endmodule

// File: tb/tb_player_tracker.sv
// Directed self-checking bench for player_tracker; three instances share the
// stimulus with different step budgets and a shortened timer.
module tb_player_tracker;

    logic clk = 1'b0;
    logic rst, up, down, left, right, en;

    always #5 clk = ~clk;

    logic [2:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic [5:0] a_steps, b_steps, c_steps;
    logic a_ack, a_key, a_exit, a_oos, a_to;
    logic b_ack, b_key, b_exit, b_oos, b_to;
    logic c_ack, c_key, c_exit, c_oos, c_to;

    int tests = 0;
    int fails = 0;

    player_tracker #(.CLK_HZ(10), .TIMEOUT_S(3)) dut_a (
        .clk_50MHz_i(clk), .rst_sync_ha_i(rst), .up_i(up), .down_i(down),
        .left_i(left), .right_i(right), .enable_count_last(en),
        .pos_x_o(a_x), .pos_y_o(a_y), .steps_left_o(a_steps), .move_ack_o(a_ack),
        .in_key_pos(a_key), .in_exit_pos(a_exit), .out_of_steps(a_oos), .timeout_15s(a_to)
    );

    player_tracker #(.MAX_STEPS(3), .CLK_HZ(10), .TIMEOUT_S(3)) dut_b (
        .clk_50MHz_i(clk), .rst_sync_ha_i(rst), .up_i(up), .down_i(down),
        .left_i(left), .right_i(right), .enable_count_last(en),
        .pos_x_o(b_x), .pos_y_o(b_y), .steps_left_o(b_steps), .move_ack_o(b_ack),
        .in_key_pos(b_key), .in_exit_pos(b_exit), .out_of_steps(b_oos), .timeout_15s(b_to)
    );

    player_tracker #(.MAX_STEPS(14), .CLK_HZ(10), .TIMEOUT_S(3)) dut_c (
        .clk_50MHz_i(clk), .rst_sync_ha_i(rst), .up_i(up), .down_i(down),
        .left_i(left), .right_i(right), .enable_count_last(en),
        .pos_x_o(c_x), .pos_y_o(c_y), .steps_left_o(c_steps), .move_ack_o(c_ack),
        .in_key_pos(c_key), .in_exit_pos(c_exit), .out_of_steps(c_oos), .timeout_15s(c_to)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // udlr = {up, down, left, right}, held for exactly one edge
    task automatic pulse(input logic [3:0] udlr);
        {up, down, left, right} = udlr;
        tick();
        {up, down, left, right} = 4'b0000;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({a_x, a_y} !== 6'd0) begin fails++; $display("FAIL reset_pos got %0d,%0d want 0,0", a_x, a_y); end
        tests++;
        if (a_steps !== 6'd40) begin fails++; $display("FAIL reset_steps got %0d want 40", a_steps); end
        tests++;
        if ({a_ack, a_key, a_exit, a_oos, a_to} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {a_ack, a_key, a_exit, a_oos, a_to});
        end
    endtask

    task automatic test_start_key();
        int acks = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pulse(i < 5 ? 4'b0001 : 4'b0100);
            if (a_ack === 1'b1) acks++;
        end
        tick();
        tests++;
        if (a_ack !== 1'b0) begin fails++; $display("FAIL ack_one_cycle got %b want 0", a_ack); end
        tests++;
        if (acks != 7) begin fails++; $display("FAIL ack_count got %0d want 7", acks); end
        tests++;
        if ({a_x, a_y} !== {3'd5, 3'd2}) begin fails++; $display("FAIL key_pos got %0d,%0d want 5,2", a_x, a_y); end
        tests++;
        if (a_key !== 1'b1) begin fails++; $display("FAIL in_key got %b want 1", a_key); end
        tests++;
        if (a_steps !== 6'd33) begin fails++; $display("FAIL key_steps got %0d want 33", a_steps); end
    endtask

    task automatic test_blocked();
        logic [5:0] exp_steps;
`ifdef ZORK_WALL_COST_EN
        exp_steps = 6'd39;
`else
        exp_steps = 6'd40;
`endif
        do_reset();
        pulse(4'b0010);
        tests++;
        if (a_ack !== 1'b0) begin fails++; $display("FAIL blocked_ack got %b want 0", a_ack); end
        tests++;
        if (a_steps !== exp_steps) begin fails++; $display("FAIL blocked_steps got %0d want %0d", a_steps, exp_steps); end
        pulse(4'b1001);
        tests++;
        if (a_ack !== 1'b0) begin fails++; $display("FAIL simul_ack got %b want 0", a_ack); end
        tests++;
        if ({a_x, a_y} !== 6'd0) begin fails++; $display("FAIL blocked_pos got %0d,%0d want 0,0", a_x, a_y); end
        tests++;
        if (a_steps !== exp_steps) begin fails++; $display("FAIL simul_steps got %0d want %0d", a_steps, exp_steps); end
    endtask

    task automatic test_budget();
        do_reset();
        pulse(4'b0001);
        pulse(4'b0010);
        tests++;
        if (b_steps !== 6'd1 || b_oos !== 1'b0) begin
            fails++; $display("FAIL budget_mid got steps=%0d oos=%b want 1,0", b_steps, b_oos);
        end
        pulse(4'b0001);
        tests++;
        if (b_steps !== 6'd0 || b_oos !== 1'b1) begin
            fails++; $display("FAIL budget_last got steps=%0d oos=%b want 0,1", b_steps, b_oos);
        end
        pulse(4'b0001);
        tests++;
        if ({b_x, b_y} !== {3'd1, 3'd0} || b_ack !== 1'b0) begin
            fails++; $display("FAIL budget_frozen got %0d,%0d ack=%b want 1,0 ack=0", b_x, b_y, b_ack);
        end
        tests++;
        if (b_steps !== 6'd0 || b_oos !== 1'b1) begin
            fails++; $display("FAIL budget_nowrap got steps=%0d oos=%b want 0,1", b_steps, b_oos);
        end
    endtask

    task automatic test_exit_last();
        do_reset();
        for (int i = 0; i < 13; i++) pulse(i < 7 ? 4'b0001 : 4'b0100);
        tests++;
        if ({c_x, c_y} !== {3'd7, 3'd6} || c_steps !== 6'd1 || c_exit !== 1'b0 || c_oos !== 1'b0) begin
            fails++;
            $display("FAIL exit_pre got %0d,%0d steps=%0d exit=%b oos=%b want 7,6 1 0 0",
                     c_x, c_y, c_steps, c_exit, c_oos);
        end
        pulse(4'b0100);
        tests++;
        if (c_exit !== 1'b1 || c_oos !== 1'b1 || c_steps !== 6'd0) begin
            fails++;
            $display("FAIL exit_same_edge got exit=%b oos=%b steps=%0d want 1 1 0", c_exit, c_oos, c_steps);
        end
    endtask

    task automatic test_timer();
        do_reset();
        en = 1'b1;
        repeat (12) tick();
        tests++;
        if (a_to !== 1'b0) begin fails++; $display("FAIL timer_12 got %b want 0", a_to); end
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (17) tick();
        tests++;
        if (a_to !== 1'b0) begin fails++; $display("FAIL timer_29 got %b want 0", a_to); end
        tick();
        tests++;
        if (a_to !== 1'b1) begin fails++; $display("FAIL timer_30 got %b want 1", a_to); end
        en = 1'b0;
        pulse(4'b0001);
        tick();
        tests++;
        if (a_to !== 1'b1) begin fails++; $display("FAIL timer_sticky got %b want 1", a_to); end
        tests++;
        if ({a_x, a_y} !== 6'd0 || a_steps !== 6'd40) begin
            fails++; $display("FAIL frozen_after_exit got %0d,%0d steps=%0d want 0,0 40", a_x, a_y, a_steps);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(4'b0001);
        en = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (a_to !== 1'b0 || {a_x, a_y} !== 6'd0 || a_steps !== 6'd40) begin
            fails++;
            $display("FAIL reset_mid got to=%b pos=%0d,%0d steps=%0d want 0 0,0 40", a_to, a_x, a_y, a_steps);
        end
        repeat (29) tick();
        tests++;
        if (a_to !== 1'b0) begin fails++; $display("FAIL reset_mid_29 got %b want 0", a_to); end
        tick();
        tests++;
        if (a_to !== 1'b1) begin fails++; $display("FAIL reset_mid_30 got %b want 1", a_to); end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; en = 1'b0;
        #2;
        test_reset();
        test_start_key();
        test_blocked();
        test_budget();
        test_exit_last();
        test_timer();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
